sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between three requesters: the VGA scan-out reader, the CPU data port and the blitter.
- VGA has absolute priority, with a bounded-starvation guard so the other two still make progress. CPU and blitter share the remaining bandwidth round-robin.
- Sits between vga_output / CPU / blitter and the SDRAM controller. It latches the winning request and forwards ack/valid/complete back to the owner only.

Parameters:
- VGA_BURST, 8: words per VGA read burst (fixed length; VGA is read-only).
- VGA_MAX_CONSEC, 4: consecutive VGA grants allowed while CPU/blit is pending before one non-VGA grant is forced.
- ADDR_W, 26: byte address width.

Ports:
- clock  in  1  system clock, 100MHz.
- reset  in  1  asynchronous, active-high.
- vga_request  in  1  VGA read request; held until vga_ack.
- vga_address  in  ADDR_W  VGA burst start address.
- vga_ack  out  1  request accepted by the SDRAM controller.
- vga_valid  out  1  sdram_rdata is a VGA data word.
- vga_complete  out  1  VGA burst finished.
- cpu_request  in  1  CPU single-word access request.
- cpu_write  in  1  1 = write, 0 = read.
- cpu_address  in  ADDR_W  CPU address.
- cpu_wdata  in  32  CPU write data.
- cpu_wmask  in  4  CPU byte enables.
- cpu_ack  out  1  CPU request accepted.
- cpu_valid  out  1  CPU read data valid.
- cpu_complete  out  1  CPU access finished.
- blit_request, blit_write, blit_address, blit_wdata, blit_wmask, blit_ack, blit_valid, blit_complete: same as the cpu_* ports, for the blitter.
- rdata  out  32  sdram_rdata broadcast to all requesters.
- sdram_request  out  1  to controller.
- sdram_write  out  1  to controller.
- sdram_address  out  ADDR_W  to controller.
- sdram_wdata  out  32  to controller.
- sdram_wmask  out  4  to controller.
- sdram_burst  out  6  words in this access: VGA_BURST, or 1 for CPU/blit.
- sdram_ack  in  1  from controller.
- sdram_rdata  in  32  from controller.
- sdram_valid  in  1  from controller.
- sdram_complete  in  1  from controller.

Behaviour:
- Reset (async): state=IDLE, owner=NONE, rr_last=BLIT, vga_consec=0.
  - All sdram_* outputs are 0.
  - All per-requester ack/valid/complete are 0.
  - A reset mid-transaction abandons it; the controller is reset by the same signal.
- FSM states: IDLE, ISSUE, DATA.
- IDLE: if any request is high, choose a winner and latch address/write/wdata/wmask/burst into registers. Next cycle, state=ISSUE and sdram_request=1.
  - Selection rule: VGA wins unless vga_consec==VGA_MAX_CONSEC and CPU or blit is pending.
  - Otherwise, between CPU and blit, the one not equal to rr_last wins; if only one is pending, that one wins.
- ISSUE: sdram_request is held with stable latched fields until sdram_ack.
  - On sdram_ack: drop sdram_request the next cycle and go to DATA.
  - If sdram_complete arrives in the same cycle as sdram_ack, go directly to IDLE.
- DATA: wait for sdram_complete, then go to IDLE.
  - The earliest new grant is the cycle after complete, so there is one idle cycle between transactions.
- Routing is combinational from the controller (zero added latency), gated by owner:
  - x_ack = sdram_ack and owner==x.
  - x_valid = sdram_valid and owner==x.
  - x_complete = sdram_complete and owner==x.
  - rdata = sdram_rdata, unconditionally.
- Owner-bookkeeping counters (update on grant):
  - VGA grant with CPU/blit pending: vga_consec+1, saturating at VGA_MAX_CONSEC.
  - VGA grant with nothing else pending: vga_consec=0.
  - Non-VGA grant: vga_consec=0 and rr_last=winner.
- Requests seen while a transaction is outstanding are ignored and arbitrated on the next IDLE.
- Requesters must hold request until their ack. Requests are sampled only in IDLE.
- Controller valid/complete with owner==NONE (spurious) are dropped; no requester sees them.
- VGA requests are always forced to write=0 and wmask=0.

Decomposition:
- Package sdram_arb_pkg holds:
  - the state enum (IDLE/ISSUE/DATA);
  - the owner enum (NONE/VGA/CPU/BLIT);
  - a request-field struct {address, write, wdata, wmask, burst}.
- Sub-module sdram_arb_pick: combinational winner selection from {requests, vga_consec, rr_last}. It is unit-testable on its own.

Test Plan:
- VGA request alone at address 0x3f80000; controller acks 2 cycles after sdram_request, then 8 valids, then complete -> sdram_burst=8, sdram_write=0, vga_ack/vga_valid×8/vga_complete, cpu_* stay 0.
- CPU and blit both request in IDLE after reset (rr_last=BLIT) -> CPU is granted first, blit on the next IDLE, rr_last=BLIT afterwards.
- CPU pending while VGA re-requests continuously, VGA_MAX_CONSEC=4 -> grant order VGA,VGA,VGA,VGA,CPU,VGA.
- CPU write of 0xDEADBEEF, wmask=4'b0011, to address 0x100 -> sdram fields stable through ISSUE; cpu_ack then cpu_complete; no cpu_valid.
- Reset asserted during DATA of a VGA burst -> sdram_request=0 and state IDLE immediately (async); no vga_complete; a subsequent request is granted normally.
- sdram_ack and sdram_complete arrive in the same cycle -> return to IDLE; a pending blit request is granted the following cycle.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// -----------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types for the SDRAM port arbiter:
//   state_e       - arbiter FSM states (IDLE / ISSUE / DATA)
//   owner_e       - which requester currently owns the controller port
//   req_fields_t  - the request fields latched at grant time and driven to
//                   the SDRAM controller for the whole transaction
// -----------------------------------------------------------------------------
package sdram_arb_pkg;

    // Widest byte address the latched-request struct can carry. The top-level
    // ADDR_W parameter must not exceed this.
    localparam int SDRAM_ADDR_W = 26;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DATA
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_VGA,
        OWN_CPU,
        OWN_BLIT
    } owner_e;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] address;
        logic                    write;
        logic [31:0]             wdata;
        logic [3:0]              wmask;
        logic [5:0]              burst;
    } req_fields_t;

    function automatic req_fields_t pack_req(
        input logic [SDRAM_ADDR_W-1:0] address,
        input logic                    write,
        input logic [31:0]             wdata,
        input logic [3:0]              wmask,
        input logic [5:0]              burst
    );
        req_fields_t r;
        r.address = address;
        r.write   = write;
        r.wdata   = wdata;
        r.wmask   = wmask;
        r.burst   = burst;
        return r;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// -----------------------------------------------------------------------------
// sdram_arb_pick
// Combinational winner selection for the SDRAM arbiter.
//   vga_request_i   - VGA scan-out read pending
//   cpu_request_i   - CPU access pending
//   blit_request_i  - blitter access pending
//   vga_consec_i    - consecutive VGA grants made while CPU/blit was waiting
//   rr_last_i       - last non-VGA requester granted (OWN_CPU or OWN_BLIT)
//   winner_o        - requester to grant, OWN_NONE when nothing is pending
// VGA wins unless it has used up its consecutive-grant allowance while a
// CPU/blit request waits; CPU and blitter alternate round-robin.
// -----------------------------------------------------------------------------
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int VGA_MAX_CONSEC = 4,
    parameter int CONSEC_W       = 3
) (
    input  logic                vga_request_i,
    input  logic                cpu_request_i,
    input  logic                blit_request_i,
    input  logic [CONSEC_W-1:0] vga_consec_i,
    input  owner_e              rr_last_i,
    output owner_e              winner_o
);

    logic other_pending;
    logic vga_starving_others;

    assign other_pending       = cpu_request_i || blit_request_i;
    assign vga_starving_others = other_pending &&
                                 (vga_consec_i == CONSEC_W'(VGA_MAX_CONSEC));

    always_comb begin
        winner_o = OWN_NONE;
        if (vga_request_i && !vga_starving_others) begin
            winner_o = OWN_VGA;
        end else if (cpu_request_i && blit_request_i) begin
            // Both pending: the one that did not win last time goes now.
            winner_o = (rr_last_i == OWN_CPU) ? OWN_BLIT : OWN_CPU;
        end else if (cpu_request_i) begin
            winner_o = OWN_CPU;
        end else if (blit_request_i) begin
            winner_o = OWN_BLIT;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// -----------------------------------------------------------------------------
// sdram_arbiter
// Shares one SDRAM controller port between the VGA reader, the CPU and the
// blitter. The winning request is latched in IDLE, presented to the
// controller in ISSUE until sdram_ack, and the arbiter then waits in DATA for
// sdram_complete. Controller responses are routed back only to the owner.
//
// Ports
//   clock, reset                     - system clock, async active-high reset
//   vga_request/address              - VGA burst read request (read-only)
//   vga_ack/valid/complete           - VGA responses
//   cpu_*, blit_*                    - single-word read/write requesters
//   rdata                            - sdram_rdata broadcast to everyone
//   sdram_request/write/address/
//   sdram_wdata/wmask/burst          - latched request to the controller
//   sdram_ack/rdata/valid/complete   - controller responses
// -----------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int VGA_BURST      = 8,
    parameter int VGA_MAX_CONSEC = 4,
    parameter int ADDR_W         = 26
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              vga_request,
    input  logic [ADDR_W-1:0] vga_address,
    output logic              vga_ack,
    output logic              vga_valid,
    output logic              vga_complete,

    input  logic              cpu_request,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [31:0]       cpu_wdata,
    input  logic [3:0]        cpu_wmask,
    output logic              cpu_ack,
    output logic              cpu_valid,
    output logic              cpu_complete,

    input  logic              blit_request,
    input  logic              blit_write,
    input  logic [ADDR_W-1:0] blit_address,
    input  logic [31:0]       blit_wdata,
    input  logic [3:0]        blit_wmask,
    output logic              blit_ack,
    output logic              blit_valid,
    output logic              blit_complete,

    output logic [31:0]       rdata,

    output logic              sdram_request,
    output logic              sdram_write,
    output logic [ADDR_W-1:0] sdram_address,
    output logic [31:0]       sdram_wdata,
    output logic [3:0]        sdram_wmask,
    output logic [5:0]        sdram_burst,
    input  logic              sdram_ack,
    input  logic [31:0]       sdram_rdata,
    input  logic              sdram_valid,
    input  logic              sdram_complete
);

    localparam int CONSEC_W = $clog2(VGA_MAX_CONSEC + 1);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              rr_last_q, rr_last_d;
    logic [CONSEC_W-1:0] vga_consec_q, vga_consec_d;
    req_fields_t         req_q, req_d;

    owner_e              winner;
    req_fields_t         grant_fields;
    logic                other_pending;
    logic                consec_at_max;

    assign other_pending = cpu_request || blit_request;
    assign consec_at_max = (vga_consec_q == CONSEC_W'(VGA_MAX_CONSEC));

    sdram_arb_pick #(
        .VGA_MAX_CONSEC (VGA_MAX_CONSEC),
        .CONSEC_W       (CONSEC_W)
    ) u_pick (
        .vga_request_i  (vga_request),
        .cpu_request_i  (cpu_request),
        .blit_request_i (blit_request),
        .vga_consec_i   (vga_consec_q),
        .rr_last_i      (rr_last_q),
        .winner_o       (winner)
    );

    // Fields of the would-be winner; VGA is always a read of VGA_BURST words.
    always_comb begin
        grant_fields = '0;
        case (winner)
            OWN_VGA:  grant_fields = pack_req(SDRAM_ADDR_W'(vga_address), 1'b0,
                                              32'h0, 4'h0, 6'(VGA_BURST));
            OWN_CPU:  grant_fields = pack_req(SDRAM_ADDR_W'(cpu_address), cpu_write,
                                              cpu_wdata, cpu_wmask, 6'd1);
            OWN_BLIT: grant_fields = pack_req(SDRAM_ADDR_W'(blit_address), blit_write,
                                              blit_wdata, blit_wmask, 6'd1);
            default:  ;
        endcase
    end

    always_comb begin
        // NOTE: every _d defaults to its _q first, so no branch below can
        // leave a variable unassigned and infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        rr_last_d    = rr_last_q;
        vga_consec_d = vga_consec_q;
        req_d        = req_q;

        case (state_q)
            ST_IDLE: begin
                if (winner != OWN_NONE) begin
                    state_d = ST_ISSUE;
                    owner_d = winner;
                    req_d   = grant_fields;
                    if (winner == OWN_VGA) begin
                        if (other_pending) begin
                            vga_consec_d = consec_at_max ? vga_consec_q
                                                         : vga_consec_q + CONSEC_W'(1);
                        end else begin
                            vga_consec_d = '0;
                        end
                    end else begin
                        vga_consec_d = '0;
                        rr_last_d    = winner;
                    end
                end
            end

            ST_ISSUE: begin
                if (sdram_ack) begin
                    // A controller may finish within the ack cycle (e.g. a
                    // posted write); skip DATA in that case.
                    if (sdram_complete) begin
                        state_d = ST_IDLE;
                        owner_d = OWN_NONE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (sdram_complete) begin
                    state_d = ST_IDLE;
                    owner_d = OWN_NONE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order. The latched
    // request fields are reset as well because they drive sdram_* directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            rr_last_q    <= OWN_BLIT;
            vga_consec_q <= '0;
            req_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_last_q    <= rr_last_d;
            vga_consec_q <= vga_consec_d;
            req_q        <= req_d;
        end
    end

    assign sdram_request = (state_q == ST_ISSUE);
    assign sdram_write   = req_q.write;
    assign sdram_address = ADDR_W'(req_q.address);
    assign sdram_wdata   = req_q.wdata;
    assign sdram_wmask   = req_q.wmask;
    assign sdram_burst   = req_q.burst;

    // Zero-latency response routing; with owner NONE everything is dropped.
    assign vga_ack       = sdram_ack      && (owner_q == OWN_VGA);
    assign vga_valid     = sdram_valid    && (owner_q == OWN_VGA);
    assign vga_complete  = sdram_complete && (owner_q == OWN_VGA);
    assign cpu_ack       = sdram_ack      && (owner_q == OWN_CPU);
    assign cpu_valid     = sdram_valid    && (owner_q == OWN_CPU);
    assign cpu_complete  = sdram_complete && (owner_q == OWN_CPU);
    assign blit_ack      = sdram_ack      && (owner_q == OWN_BLIT);
    assign blit_valid    = sdram_valid    && (owner_q == OWN_BLIT);
    assign blit_complete = sdram_complete && (owner_q == OWN_BLIT);

    assign rdata = sdram_rdata;

endmodule

// File: tb/tb_sdram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbiter
// Self-checking bench for sdram_arbiter: a table of transactions with the
// expected winner, a scoreboard of expected controller-side fields, and
// hand-written sequences for reset behaviour and spurious responses.
// -----------------------------------------------------------------------------
module tb_sdram_arbiter;
    import sdram_arb_pkg::*;

    localparam int ADDR_W         = 26;
    localparam int VGA_BURST      = 8;
    localparam int VGA_MAX_CONSEC = 4;

    localparam logic [ADDR_W-1:0] VGA_ADDR   = 26'h3f80000;
    localparam logic [ADDR_W-1:0] CPU_ADDR   = 26'h0000100;
    localparam logic [ADDR_W-1:0] BLIT_ADDR  = 26'h0002000;
    localparam logic [31:0]       CPU_WDATA  = 32'hDEADBEEF;
    localparam logic [3:0]        CPU_WMASK  = 4'b0011;
    localparam logic [31:0]       BLIT_WDATA = 32'hA5A50001;
    localparam logic [3:0]        BLIT_WMASK = 4'b1111;

    logic              clock, reset;
    logic              vga_request;
    logic [ADDR_W-1:0] vga_address;
    logic              vga_ack, vga_valid, vga_complete;
    logic              cpu_request, cpu_write;
    logic [ADDR_W-1:0] cpu_address;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_wmask;
    logic              cpu_ack, cpu_valid, cpu_complete;
    logic              blit_request, blit_write;
    logic [ADDR_W-1:0] blit_address;
    logic [31:0]       blit_wdata;
    logic [3:0]        blit_wmask;
    logic              blit_ack, blit_valid, blit_complete;
    logic [31:0]       rdata;
    logic              sdram_request, sdram_write;
    logic [ADDR_W-1:0] sdram_address;
    logic [31:0]       sdram_wdata;
    logic [3:0]        sdram_wmask;
    logic [5:0]        sdram_burst;
    logic              sdram_ack, sdram_valid, sdram_complete;
    logic [31:0]       sdram_rdata;

    sdram_arbiter #(
        .VGA_BURST      (VGA_BURST),
        .VGA_MAX_CONSEC (VGA_MAX_CONSEC),
        .ADDR_W         (ADDR_W)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .vga_request    (vga_request),
        .vga_address    (vga_address),
        .vga_ack        (vga_ack),
        .vga_valid      (vga_valid),
        .vga_complete   (vga_complete),
        .cpu_request    (cpu_request),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_wdata      (cpu_wdata),
        .cpu_wmask      (cpu_wmask),
        .cpu_ack        (cpu_ack),
        .cpu_valid      (cpu_valid),
        .cpu_complete   (cpu_complete),
        .blit_request   (blit_request),
        .blit_write     (blit_write),
        .blit_address   (blit_address),
        .blit_wdata     (blit_wdata),
        .blit_wmask     (blit_wmask),
        .blit_ack       (blit_ack),
        .blit_valid     (blit_valid),
        .blit_complete  (blit_complete),
        .rdata          (rdata),
        .sdram_request  (sdram_request),
        .sdram_write    (sdram_write),
        .sdram_address  (sdram_address),
        .sdram_wdata    (sdram_wdata),
        .sdram_wmask    (sdram_wmask),
        .sdram_burst    (sdram_burst),
        .sdram_ack      (sdram_ack),
        .sdram_rdata    (sdram_rdata),
        .sdram_valid    (sdram_valid),
        .sdram_complete (sdram_complete)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        owner_e            owner;
        logic [ADDR_W-1:0] address;
        logic              write;
        logic [31:0]       wdata;
        logic [3:0]        wmask;
        logic [5:0]        burst;
    } exp_t;

    typedef struct {
        bit     raise_vga;
        bit     raise_cpu;
        bit     raise_blit;
        bit     cpu_wr;
        owner_e exp_owner;
        int     ack_delay;
        bit     same_cycle;
    } vec_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [2:0] onehot(input owner_e o);
        case (o)
            OWN_VGA:  return 3'b100;
            OWN_CPU:  return 3'b010;
            OWN_BLIT: return 3'b001;
            default:  return 3'b000;
        endcase
    endfunction

    function automatic exp_t expect_for(input owner_e o);
        exp_t e;
        e.owner = o;
        case (o)
            OWN_VGA: begin
                e.address = VGA_ADDR;  e.write = 1'b0; e.wdata = 32'h0;
                e.wmask = 4'h0;        e.burst = 6'(VGA_BURST);
            end
            OWN_CPU: begin
                e.address = CPU_ADDR;  e.write = cpu_write; e.wdata = CPU_WDATA;
                e.wmask = CPU_WMASK;   e.burst = 6'd1;
            end
            default: begin
                e.address = BLIT_ADDR; e.write = 1'b1; e.wdata = BLIT_WDATA;
                e.wmask = BLIT_WMASK;  e.burst = 6'd1;
            end
        endcase
        return e;
    endfunction

    function automatic logic [2:0] acks();      return {vga_ack, cpu_ack, blit_ack};                endfunction
    function automatic logic [2:0] valids();    return {vga_valid, cpu_valid, blit_valid};          endfunction
    function automatic logic [2:0] completes(); return {vga_complete, cpu_complete, blit_complete}; endfunction

    // Raise the requests in v, then act as the controller for one transaction.
    task automatic run_txn(input vec_t v, input string tag);
        exp_t       e;
        int         waited;
        int         nvalid;
        logic [2:0] oh;
        if (v.raise_vga)  vga_request = 1'b1;
        if (v.raise_cpu) begin
            cpu_write   = v.cpu_wr;
            cpu_request = 1'b1;
        end
        if (v.raise_blit) blit_request = 1'b1;
        sb_q.push_back(expect_for(v.exp_owner));

        waited = 0;
        while (!sdram_request && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_grant_latency"}, 64'(waited), 64'd1);
        e = sb_q.pop_front();
        if (!sdram_request) return;

        oh = onehot(e.owner);
        check({tag, "_address"}, 64'(sdram_address), 64'(e.address));
        check({tag, "_write"},   64'(sdram_write),   64'(e.write));
        check({tag, "_burst"},   64'(sdram_burst),   64'(e.burst));
        check({tag, "_wmask"},   64'(sdram_wmask),   64'(e.wmask));
        if (e.owner != OWN_VGA) check({tag, "_wdata"}, 64'(sdram_wdata), 64'(e.wdata));

        for (int i = 0; i < v.ack_delay; i++) begin
            tick();
            check({tag, "_req_held"}, 64'({sdram_request, sdram_address, sdram_write}),
                  64'({1'b1, e.address, e.write}));
        end

        sdram_ack      = 1'b1;
        sdram_complete = v.same_cycle;
        #1;
        check({tag, "_ack_route"}, 64'(acks()), 64'(oh));
        if (v.same_cycle) check({tag, "_fast_complete_route"}, 64'(completes()), 64'(oh));
        tick();
        sdram_ack      = 1'b0;
        sdram_complete = 1'b0;
        case (e.owner)
            OWN_VGA:  vga_request  = 1'b0;
            OWN_CPU:  cpu_request  = 1'b0;
            OWN_BLIT: blit_request = 1'b0;
            default:  ;
        endcase
        #1;
        check({tag, "_req_dropped"}, 64'(sdram_request), 64'd0);

        if (!v.same_cycle) begin
            nvalid = (e.owner == OWN_VGA) ? VGA_BURST : (e.write ? 0 : 1);
            for (int i = 0; i < nvalid; i++) begin
                sdram_valid = 1'b1;
                sdram_rdata = 32'hC0DE0000 + 32'(i);
                #1;
                check({tag, "_valid_route"}, 64'({valids(), rdata}),
                      64'({oh, 32'hC0DE0000 + 32'(i)}));
                tick();
                sdram_valid = 1'b0;
            end
            sdram_complete = 1'b1;
            #1;
            check({tag, "_complete_route"}, 64'({completes(), valids()}), 64'({oh, 3'b000}));
            tick();
            sdram_complete = 1'b0;
        end
    endtask

    vec_t vecs[12];
    vec_t post_reset[3];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, expected finish");
        $fatal(1);
    end

    initial begin
        int waited;

        //             vga  cpu  blit wr  expected   dly same
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, OWN_VGA,  2, 1'b0}; // lone VGA burst
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, OWN_CPU,  1, 1'b0}; // rr_last=BLIT -> CPU
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, OWN_BLIT, 0, 1'b0}; // held blit next
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, OWN_CPU,  3, 1'b0}; // CPU write
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, OWN_VGA,  1, 1'b0}; // consec 1
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, OWN_VGA,  1, 1'b0}; // consec 2
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, OWN_VGA,  1, 1'b0}; // consec 3
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, OWN_VGA,  1, 1'b0}; // consec 4
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, OWN_CPU,  1, 1'b0}; // forced non-VGA
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, OWN_VGA,  1, 1'b0}; // VGA resumes
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, OWN_BLIT, 1, 1'b1}; // rr_last=CPU, ack+complete
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, OWN_CPU,  1, 1'b0}; // held CPU right after

        post_reset[0] = '{1'b1, 1'b0, 1'b0, 1'b0, OWN_VGA,  1, 1'b0};
        post_reset[1] = '{1'b0, 1'b1, 1'b1, 1'b0, OWN_CPU,  1, 1'b0}; // rr_last back to BLIT
        post_reset[2] = '{1'b0, 1'b0, 1'b0, 1'b0, OWN_BLIT, 1, 1'b0};

        reset          = 1'b1;
        vga_request    = 1'b0; vga_address  = VGA_ADDR;
        cpu_request    = 1'b0; cpu_write    = 1'b0; cpu_address  = CPU_ADDR;
        cpu_wdata      = CPU_WDATA;  cpu_wmask  = CPU_WMASK;
        blit_request   = 1'b0; blit_write   = 1'b1; blit_address = BLIT_ADDR;
        blit_wdata     = BLIT_WDATA; blit_wmask = BLIT_WMASK;
        sdram_ack      = 1'b1;
        sdram_valid    = 1'b1;
        sdram_complete = 1'b1;
        sdram_rdata    = 32'h12345678;
        repeat (3) tick();

        // Reset state, with controller strobes forced high to show they are
        // dropped while nobody owns the port.
        check("reset_sdram_outputs",
              64'({sdram_request, sdram_write, sdram_wdata, sdram_wmask, sdram_burst}), 64'd0);
        check("reset_sdram_address", 64'(sdram_address), 64'd0);
        check("reset_routing", 64'({acks(), valids(), completes()}), 64'd0);
        check("rdata_broadcast", 64'(rdata), 64'h12345678);
        sdram_ack      = 1'b0;
        sdram_valid    = 1'b0;
        sdram_complete = 1'b0;
        reset          = 1'b0;
        tick();

        for (int i = 0; i < 12; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a VGA burst's data phase.
        vga_request = 1'b1;
        waited = 0;
        while (!sdram_request && waited < 20) begin
            tick();
            waited++;
        end
        check("rst_seq_grant", 64'(sdram_request), 64'd1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack   = 1'b0;
        vga_request = 1'b0;
        sdram_valid = 1'b1;
        sdram_rdata = 32'h0BADF00D;
        repeat (3) tick();
        check("rst_seq_valid_before", 64'({valids(), sdram_burst}), 64'({3'b100, 6'd8}));
        #2;
        reset = 1'b1;
        #1;
        check("rst_seq_async_gate", 64'(valids()), 64'd0);
        check("rst_seq_async_outputs", 64'({sdram_request, sdram_burst}), 64'd0);
        sdram_complete = 1'b1;
        #1;
        check("rst_seq_no_complete", 64'(completes()), 64'd0);
        tick();
        sdram_valid    = 1'b0;
        sdram_complete = 1'b0;
        reset          = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) run_txn(post_reset[i], $sformatf("post_rst%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
